uart_tx_arbiter: RTL

- Shares one UART transmit byte stream among NumReq on-chip requesters, for example the core's console driver and a debug/trace source.
- Grants are line-atomic and round-robin: a granted requester owns the transmitter until it sends a newline, hits the line-length cap, or goes idle past a timeout.
- Sits between the requesters and the UART TX FIFO input, so the testbench UART monitor never sees interleaved partial lines.

---
 rtl/uart_arb_pkg.sv | 10 +
 rtl/uart_arb_rr_sel.sv | 17 +
 rtl/uart_tx_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and byte constants for the UART TX arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TAG = 2'd1, DATA = 2'd2} arb_state_e;
  localparam logic [7:0] NewlineChar  = 8'h0A;
  localparam logic [7:0] TagBaseDigit = 8'h30;
  localparam logic [7:0] TagBaseAlpha = 8'h41;
  function automatic logic [7:0] tag_char(input logic [3:0] id);
    return id < 4'd10 ? TagBaseDigit + {4'd0, id} : TagBaseAlpha + {4'd0, id - 4'd10};
  endfunction
endpackage

// File: rtl/uart_arb_rr_sel.sv
// uart_arb_rr_sel: cyclic first-one search starting at the round-robin pointer.
module uart_arb_rr_sel #(
  parameter int NumReq = 4,
  localparam int IdW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdW-1:0]    ptr,
  output logic [IdW-1:0]    idx,
  output logic              any
);
  always_comb begin
    idx = ptr;
    for (int i = NumReq - 1; i >= 0; i--)
      if (valid[(int'(ptr) + i) % NumReq]) idx = IdW'((int'(ptr) + i) % NumReq);
  end
  assign any = |valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: line-atomic round-robin sharing of one UART TX byte stream.
// Define UART_ARB_TAG_EN to prefix each grant with an ASCII requester-id tag byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int MaxLineLen    = 80,
  parameter int TimeoutCycles = 1024,
  localparam int IdW  = $clog2(NumReq),
  localparam int CntW = $clog2(MaxLineLen + 1),
  localparam int TmrW = TimeoutCycles == 0 ? 1 : $clog2(TimeoutCycles + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq-1:0][7:0] req_data_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic [IdW-1:0]         grant_id_o,
  output logic                   busy_o
);
  localparam int TmrLast = TimeoutCycles == 0 ? 0 : TimeoutCycles - 1;
`ifdef UART_ARB_TAG_EN
  localparam arb_state_e First = TAG;
`else
  localparam arb_state_e First = DATA;
`endif
  arb_state_e state;
  logic [IdW-1:0] gnt, rr_ptr, sel;
  logic [CntW-1:0] byte_cnt;
  logic [TmrW-1:0] idle_tmr;
  logic any, gv, hs, rel;
  logic [7:0] gd;
  uart_arb_rr_sel #(.NumReq(NumReq)) u_sel (
    .valid(req_valid_i),
    .ptr  (rr_ptr),
    .idx  (sel),
    .any  (any)
  );
  assign gv = req_valid_i[gnt];
  assign gd = req_data_i[gnt];
  assign hs = state == DATA && gv && tx_ready_i;
  // newline and length cap share one release so a capped newline releases once
  assign rel = state == DATA && ((hs && (gd == NewlineChar || int'(byte_cnt) + 1 == MaxLineLen)) ||
               (!gv && TimeoutCycles != 0 && int'(idle_tmr) == TmrLast));
  assign busy_o = state != IDLE;
  assign grant_id_o = gnt;
  assign req_ready_o = state == DATA && tx_ready_i ? NumReq'(1) << gnt : '0;
`ifdef UART_ARB_TAG_EN
  assign tx_valid_o = state == DATA ? gv : state == TAG;
  assign tx_data_o = state == DATA ? gd : state == TAG ? tag_char(4'(gnt)) : 8'h00;
`else
  assign tx_valid_o = state == DATA && gv;
  assign tx_data_o = state == DATA ? gd : 8'h00;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      byte_cnt <= '0;
      idle_tmr <= '0;
    end else if (state == IDLE) begin
      byte_cnt <= '0;
      idle_tmr <= '0;
      if (any) begin
        gnt <= sel;
        state <= First;
      end
    end
`ifdef UART_ARB_TAG_EN
    else if (state == TAG) begin
      if (tx_ready_i) state <= DATA;
    end
`endif
    else begin
      byte_cnt <= hs ? byte_cnt + 1'b1 : byte_cnt;
      idle_tmr <= gv ? '0 : &idle_tmr ? idle_tmr : idle_tmr + 1'b1;
      if (rel) begin
        state <= IDLE;
        rr_ptr <= int'(gnt) == NumReq - 1 ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule
